// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave with configurable word width, SPI mode and bit
// order. All pins are resynchronised into the clk domain. Received words are
// presented as rx_data with a one-cycle rx_valid strobe. Transmit words go
// through a single holding register with a valid/ready handshake, and FILL is
// shifted out whenever that register is empty at a word boundary.
module spi_slave_core #(
    parameter int                DATA_W    = 8,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] FILL      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int              CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [2:0]        r_sck_sync;
    logic [2:0]        r_ssel_sync;
    logic [1:0]        r_mosi_sync;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_tx_buf;
    logic              r_tx_full;
    logic              r_tx_underrun;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_lead;
    logic              w_trail;
    logic              w_sel_active;
    logic              w_start_msg;
    logic              w_sample;
    logic              w_shift;
    logic              w_load;
    logic              w_word_done;
    logic              w_tx_hs;
    logic [DATA_W-1:0] w_rx_next;

    // Edge detection on the two oldest sync stages; the MOSI bit in stage 1
    // lines up with the SCK edge seen between stages 1 and 2.
    assign w_sck_rise   = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall   = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_lead       = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail      = CPOL ? w_sck_rise : w_sck_fall;
    assign w_sel_active = ~r_ssel_sync[1];
    assign w_start_msg  = ~r_ssel_sync[1] & r_ssel_sync[2];

    // SCK activity outside an active select is ignored entirely.
    assign w_sample     = w_sel_active & (CPHA ? w_trail : w_lead);
    assign w_shift      = w_sel_active & (CPHA ? w_lead : w_trail);
    assign w_load       = (w_shift && (r_bitcnt == '0)) || (!CPHA && w_start_msg);
    assign w_word_done  = w_sample && (r_bitcnt == LAST);
    assign w_tx_hs      = tx_valid && !r_tx_full;

    assign w_rx_next = MSB_FIRST ? {r_rx_sh[DATA_W-2:0], r_mosi_sync[1]}
                                 : {r_mosi_sync[1], r_rx_sh[DATA_W-1:1]};

    assign MISO        = MSB_FIRST ? r_tx_sh[DATA_W-1] : r_tx_sh[0];
    assign miso_oe     = w_sel_active;
    assign tx_ready    = !r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign busy        = w_sel_active && (r_bitcnt != '0);

    // Pin synchronisers, reset to the idle bus state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= {3{CPOL}};
            r_ssel_sync <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], SCK};
            r_ssel_sync <= {r_ssel_sync[1:0], SSEL};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
        end
    end

    // Bit counter and receive shifter; deselect discards any partial word.
    always_ff @(posedge clk) begin
        if (rst || !w_sel_active) begin
            r_bitcnt <= '0;
            r_rx_sh  <= '0;
        end else if (w_sample) begin
            r_bitcnt <= (r_bitcnt == LAST) ? '0 : r_bitcnt + 1'b1;
            r_rx_sh  <= w_rx_next;
        end
    end

    // Publish a completed word with a single-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_word_done;
            if (w_word_done) begin
                r_rx_data <= w_rx_next;
            end
        end
    end

    // Transmit holding register and output shifter. A load while empty takes
    // FILL; a handshake in that same cycle still lands in the holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sh       <= '0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (!w_sel_active) begin
                r_tx_sh <= '0;
            end else if (w_load) begin
                if (r_tx_full) begin
                    r_tx_sh   <= r_tx_buf;
                    r_tx_full <= 1'b0;
                end else begin
                    r_tx_sh       <= FILL;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_tx_sh <= MSB_FIRST ? {r_tx_sh[DATA_W-2:0], 1'b0}
                                     : {1'b0, r_tx_sh[DATA_W-1:1]};
            end
            if (w_tx_hs) begin
                r_tx_buf  <= tx_data;
                r_tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: four 8-bit MSB-first instances (one per SPI mode,
// FILL=0xFF) and one 16-bit LSB-first mode-0 instance (FILL=0xA55A), driven one
// at a time by a bit-banged master. Expected words come from a word-level
// model of the transmit buffer; a monitor pops received words and counts
// underrun strobes.
module tb_spi_slave_core;

    localparam int NI = 5;
    localparam int H  = 6;  // clk cycles per SCK half period

    typedef struct {
        int          idx;
        logic [15:0] data;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic sck[NI], ssel[NI], mosi[NI], txv[NI];
    logic miso[NI], oe[NI], txr[NI], rxv[NI], und[NI], bsy[NI];
    logic [7:0]  txd8[4], rxd8[4];
    logic [15:0] txd16, rxd16;

    int vectors = 0;
    int errors  = 0;

    rx_exp_t     rxq[$];
    int          und_cnt[NI];
    int          mund[NI];
    bit          mfull[NI];
    logic [15:0] mbuf[NI];
    logic [15:0] last_rx[NI];

    logic [15:0] m_mosi[8];
    logic [15:0] m_wrv[8];
    bit          m_wren[8];
    logic [15:0] exp_miso[8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_m
        spi_slave_core #(
            .DATA_W(8), .CPOL(bit'((g / 2) % 2)), .CPHA(bit'(g % 2)),
            .MSB_FIRST(1'b1), .FILL(8'hFF)
        ) u_dut (
            .clk(clk), .rst(rst), .SCK(sck[g]), .SSEL(ssel[g]), .MOSI(mosi[g]),
            .MISO(miso[g]), .miso_oe(oe[g]), .tx_data(txd8[g]), .tx_valid(txv[g]),
            .tx_ready(txr[g]), .rx_data(rxd8[g]), .rx_valid(rxv[g]),
            .tx_underrun(und[g]), .busy(bsy[g])
        );
    end

    spi_slave_core #(
        .DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .FILL(16'hA55A)
    ) u_dut16 (
        .clk(clk), .rst(rst), .SCK(sck[4]), .SSEL(ssel[4]), .MOSI(mosi[4]),
        .MISO(miso[4]), .miso_oe(oe[4]), .tx_data(txd16), .tx_valid(txv[4]),
        .tx_ready(txr[4]), .rx_data(rxd16), .rx_valid(rxv[4]),
        .tx_underrun(und[4]), .busy(bsy[4])
    );

    function automatic int wd(int i);       return (i == 4) ? 16 : 8;            endfunction
    function automatic bit cpol(int i);     return (i == 4) ? 1'b0 : bit'((i / 2) % 2); endfunction
    function automatic bit cpha(int i);     return (i == 4) ? 1'b0 : bit'(i % 2);  endfunction
    function automatic bit msb(int i);      return (i != 4);                     endfunction
    function automatic logic [15:0] fill(int i); return (i == 4) ? 16'hA55A : 16'h00FF; endfunction
    function automatic logic [15:0] mask(int i); return (i == 4) ? 16'hFFFF : 16'h00FF; endfunction

    function automatic logic [15:0] get_rx(int i);
        if (i == 4) return rxd16;
        return {8'h00, rxd8[i]};
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_tx(int i, logic [15:0] v);
        if (i == 4) txd16 = v;
        else        txd8[i] = v[7:0];
        txv[i] = 1'b1;
        @(negedge clk);
        txv[i] = 1'b0;
    endtask

    // Preload through the handshake; the model decides whether it is accepted.
    task automatic tx_write(int i, logic [15:0] v);
        chk("tx_ready_pre", 16'(txr[i]), 16'(!mfull[i]));
        if (!mfull[i]) begin
            drive_tx(i, v);
            mfull[i] = 1'b1;
            mbuf[i]  = v;
            chk("tx_ready_buffered", 16'(txr[i]), 16'(0));
        end
    endtask

    // Word-level model: a message with n whole words and p trailing bits sees
    // one load per word, plus the select-edge load when CPHA=0 (which, with
    // the load at each word's final shift edge, gives n+1 loads).
    task automatic plan(int i, int n, int p);
        int          loads;
        logic [15:0] w;
        loads = (cpha(i) == 1'b0) ? n + 1 : n + ((p > 0) ? 1 : 0);
        for (int l = 0; l < loads; l++) begin
            if (mfull[i]) begin
                w = mbuf[i];
                mfull[i] = 1'b0;
            end else begin
                w = fill(i);
                mund[i]++;
            end
            if (l < n) begin
                exp_miso[l] = w;
                if (m_wren[l] && !mfull[i]) begin
                    mfull[i] = 1'b1;
                    mbuf[i]  = m_wrv[l];
                end else begin
                    m_wren[l] = 1'b0;
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            rxq.push_back('{i, m_mosi[k]});
            last_rx[i] = m_mosi[k];
        end
    endtask

    task automatic clr_plan();
        for (int k = 0; k < 8; k++) begin
            m_wren[k] = 1'b0;
            m_wrv[k]  = '0;
            m_mosi[k] = '0;
        end
    endtask

    // Bit-banged master; the master samples MISO just before its own sample edge.
    task automatic run_msg(int i, int n, int p);
        int          bits;
        int          bi;
        int          w;
        bit          pol;
        logic [15:0] rw;
        w   = wd(i);
        pol = cpol(i);
        ssel[i] = 1'b0;
        wait_clk(H);
        for (int k = 0; k <= n; k++) begin
            bits = (k < n) ? w : p;
            rw   = '0;
            for (int b = 0; b < bits; b++) begin
                bi = msb(i) ? (w - 1 - b) : b;
                if (b == w / 2 && k < n && m_wren[k]) begin
                    chk("tx_ready_empty", 16'(txr[i]), 16'(1));
                    drive_tx(i, m_wrv[k]);
                    chk("tx_ready_held", 16'(txr[i]), 16'(0));
                end
                if (!cpha(i)) begin
                    mosi[i] = m_mosi[k][bi];
                    wait_clk(H);
                    rw[bi] = miso[i];
                    sck[i] = !pol;
                    wait_clk(H);
                    sck[i] = pol;
                end else begin
                    sck[i]  = !pol;
                    mosi[i] = m_mosi[k][bi];
                    wait_clk(H);
                    rw[bi] = miso[i];
                    sck[i] = pol;
                    wait_clk(H);
                end
                if (k == 0 && b == 0) begin
                    chk("busy_mid_word", 16'(bsy[i]), 16'(1));
                    chk("miso_oe_active", 16'(oe[i]), 16'(1));
                end
            end
            if (k < n) chk($sformatf("miso_word[%0d] inst%0d", k, i), rw, exp_miso[k]);
        end
        wait_clk(H);
        ssel[i] = 1'b1;
        wait_clk(8);
        chk("busy_idle", 16'(bsy[i]), 16'(0));
        chk("miso_oe_idle", 16'(oe[i]), 16'(0));
        chk($sformatf("underruns inst%0d", i), 16'(und_cnt[i]), 16'(mund[i]));
    endtask

    // Monitor: every rx_valid pops one expected word; underrun strobes counted.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rxv[i]) begin
                vectors++;
                if (rxq.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected inst%0d: got %h, expected no word", i, get_rx(i));
                end else begin
                    rx_exp_t e;
                    e = rxq.pop_front();
                    if (e.idx != i || get_rx(i) !== e.data) begin
                        errors++;
                        $display("FAIL rx_word: got inst%0d %h, expected inst%0d %h", i, get_rx(i), e.idx, e.data);
                    end
                end
            end
            if (und[i] === 1'b1) und_cnt[i]++;
        end
    end

    initial begin
        #900us;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        int i, n, p;
        rst = 1'b1;
        txd16 = '0;
        for (int k = 0; k < NI; k++) begin
            sck[k] = cpol(k); ssel[k] = 1'b1; mosi[k] = 1'b0; txv[k] = 1'b0;
            und_cnt[k] = 0; mund[k] = 0; mfull[k] = 1'b0; mbuf[k] = '0; last_rx[k] = '0;
        end
        for (int k = 0; k < 4; k++) txd8[k] = '0;
        clr_plan();
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);

        // Reset state of every instance
        for (int k = 0; k < NI; k++) begin
            chk("rst_tx_ready", 16'(txr[k]), 16'(1));
            chk("rst_miso_oe", 16'(oe[k]), 16'(0));
            chk("rst_busy", 16'(bsy[k]), 16'(0));
            chk("rst_rx_data", get_rx(k), 16'h0000);
        end

        // Mode 0: preload 0x3C, master sends 0xA5
        clr_plan(); tx_write(0, 16'h003C); m_mosi[0] = 16'h00A5;
        plan(0, 1, 0); run_msg(0, 1, 0);
        chk("tx_ready_after_load", 16'(txr[0]), 16'(1));

        // Modes 3, 1, 2: preload 0xC3, master sends 0x5A
        for (int m = 3; m >= 1; m--) begin
            clr_plan(); tx_write(m, 16'h00C3); m_mosi[0] = 16'h005A;
            plan(m, 1, 0); run_msg(m, 1, 0);
        end

        // Nothing buffered: two words read back FILL in mode 0 and mode 1
        for (int m = 0; m < 2; m++) begin
            clr_plan(); m_mosi[0] = 16'h0012 + 16'(m); m_mosi[1] = 16'h0034;
            plan(m, 2, 0); run_msg(m, 2, 0);
        end

        // Buffer 0x11, write 0x22 during word 1, three words
        clr_plan(); tx_write(0, 16'h0011);
        m_wren[0] = 1'b1; m_wrv[0] = 16'h0022;
        m_mosi[0] = 16'h0001; m_mosi[1] = 16'h0002; m_mosi[2] = 16'h0003;
        plan(0, 3, 0); run_msg(0, 3, 0);

        // Abort after 3 bits, then a full 0x96
        clr_plan(); m_mosi[0] = 16'h00E7;
        plan(0, 0, 3); run_msg(0, 0, 3);
        chk("rx_data_kept_after_abort", get_rx(0), last_rx[0]);
        clr_plan(); m_mosi[0] = 16'h0096;
        plan(0, 1, 0); run_msg(0, 1, 0);
        chk("rx_data_after_abort", get_rx(0), 16'h0096);

        // 16-bit LSB-first: preload 0xBEEF, master sends 0x1234
        clr_plan(); tx_write(4, 16'hBEEF); m_mosi[0] = 16'h1234;
        plan(4, 1, 0); run_msg(4, 1, 0);

        // Randomised messages
        for (int t = 0; t < 24; t++) begin
            clr_plan();
            i = $urandom_range(0, NI - 1);
            n = $urandom_range(1, 3);
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, wd(i) - 1) : 0;
            if ($urandom_range(0, 1) == 1) tx_write(i, 16'($urandom) & mask(i));
            for (int k = 0; k <= n; k++) begin
                m_mosi[k] = 16'($urandom) & mask(i);
                m_wren[k] = bit'($urandom_range(0, 1));
                m_wrv[k]  = 16'($urandom) & mask(i);
            end
            plan(i, n, p); run_msg(i, n, p);
        end

        // Reset in the middle of a word with a word buffered
        clr_plan(); tx_write(0, 16'h0077);
        ssel[0] = 1'b0; wait_clk(H);
        mfull[0] = 1'b0;  // consumed by the select-edge load
        mosi[0] = 1'b1; wait_clk(H); sck[0] = 1'b1; wait_clk(H);
        sck[0] = 1'b0; wait_clk(H); sck[0] = 1'b1; wait_clk(3);
        tx_write(0, 16'h0088);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx_ready", 16'(txr[0]), 16'(1));
        chk("midrst_miso_oe", 16'(oe[0]), 16'(0));
        chk("midrst_busy", 16'(bsy[0]), 16'(0));
        chk("midrst_rx_valid", 16'(rxv[0]), 16'(0));
        chk("midrst_underrun", 16'(und[0]), 16'(0));
        chk("midrst_miso", 16'(miso[0]), 16'(0));
        chk("midrst_rx_data", get_rx(0), 16'h0000);
        ssel[0] = 1'b1; sck[0] = 1'b0; mosi[0] = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            mfull[k] = 1'b0;
            last_rx[k] = '0;
        end
        wait_clk(4);

        // Normal operation resumes after reset
        clr_plan(); tx_write(0, 16'h005C); m_mosi[0] = 16'h00C5;
        plan(0, 1, 0); run_msg(0, 1, 0);

        wait_clk(10);
        chk("rx_queue_drained", 16'(rxq.size()), 16'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
